// File: rtl/rv32_instr_stim_gen.sv
// -----------------------------------------------------------------------------
// rv32_instr_stim_gen
//
// Seeded RV32I instruction stimulus generator for the instruction-memory
// response port of the sodor5 harness. After reset it emits WARMUP_NOPS NOPs,
// then a pseudo-random stream of ALU-imm / load / store / ALU-reg words derived
// from a 32-bit Galois LFSR, then NOPs forever once NUM_INSTR random words
// have been accepted. The same SEED and parameters always produce the same
// stream.
//
// Parameters:
//   SEED          initial LFSR state (0 is replaced by 1)
//   NUM_INSTR     random instructions before done (0 = unlimited)
//   WARMUP_NOPS   NOPs emitted after reset before the random stream
//   CLASS_MASK    class enables: bit0 ALUI, bit1 LOAD, bit2 STORE, bit3 ALUR
//   LOAD_F3_MASK  AND-mask applied to the load funct3
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   en           in   allow loading a new word
//   instr_ready  in   consumer accepts instr this cycle
//   instr_valid  out  instr holds a valid word
//   instr        out  32-bit instruction word (registered)
//   instr_class  out  0 ALUI, 1 LOAD, 2 STORE, 3 ALUR (NOPs report 0)
//   instr_count  out  random instructions transferred, saturating
//   done         out  NUM_INSTR reached (sticky until reset)
// -----------------------------------------------------------------------------
module rv32_instr_stim_gen #(
    parameter logic [31:0] SEED         = 32'h00000017,
    parameter int unsigned NUM_INSTR    = 100,
    parameter int unsigned WARMUP_NOPS  = 2,
    parameter logic [3:0]  CLASS_MASK   = 4'b0011,
    parameter logic [2:0]  LOAD_F3_MASK = 3'b100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [1:0]  instr_class,
    output logic [15:0] instr_count,
    output logic        done
);

    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Galois LFSR step
    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        logic [31:0] v;
        v = {1'b0, r[31:1]};
        if (r[0]) begin
            v = v ^ LFSR_TAPS;
        end else begin
            v = v;
        end
        return v;
    endfunction

    // Map an LFSR state to {class, instruction word}
    function automatic logic [33:0] encode(input logic [31:0] r);
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [2:0]  f;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic [1:0]  sel;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [1:0]  s3;
        logic [1:0]  cls;
        logic [31:0] w;
        rd  = r[6:2];
        rs1 = r[11:7];
        rs2 = r[16:12];
        f3  = r[19:17];
        imm = r[31:20];
        sel = r[1:0];
        s1  = sel + 2'd1;
        s2  = sel + 2'd2;
        s3  = sel + 2'd3;
        f   = 3'd0;
        f7  = 7'd0;
        w   = NOP;
        // A disabled selection rolls upward (mod 4) to the next enabled class
        if (CLASS_MASK[sel]) begin
            cls = sel;
        end else if (CLASS_MASK[s1]) begin
            cls = s1;
        end else if (CLASS_MASK[s2]) begin
            cls = s2;
        end else begin
            cls = s3;
        end
        case (cls)
            2'd0: begin
                // Shift-immediates keep only the shamt (and the SRAI bit)
                case (f3)
                    3'd5:    imm = imm & 12'h41F;
                    3'd1:    imm = imm & 12'h01F;
                    default: imm = imm;
                endcase
                w = {imm, rs1, f3, rd, 7'b0010011};
            end
            2'd1: begin
                // Unused load widths fold onto LW
                f = f3 & LOAD_F3_MASK;
                if (f == 3'd3 || f == 3'd6 || f == 3'd7) begin
                    f = 3'd2;
                end else begin
                    f = f;
                end
                w = {imm, rs1, f, rd, 7'b0000011};
            end
            2'd2: begin
                f = {1'b0, f3[1:0]};
                if (f == 3'd3) begin
                    f = 3'd2;
                end else begin
                    f = f;
                end
                w = {imm[11:5], rs2, rs1, f, imm[4:0], 7'b0100011};
            end
            2'd3: begin
                // SUB / SRA only exist for funct3 0 and 5
                if ((f3 == 3'd0 || f3 == 3'd5) && r[20]) begin
                    f7 = 7'b0100000;
                end else begin
                    f7 = 7'b0000000;
                end
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            default: w = NOP;
        endcase
        if (CLASS_MASK == 4'b0000) begin
            return {2'd0, NOP};
        end else begin
            return {cls, w};
        end
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_nxt;
    logic [31:0] r_wcnt;
    logic [31:0] w_wcnt_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [1:0]  r_class;
    logic [1:0]  w_class_nxt;

    logic        w_xfer;
    logic        w_load;
    logic [31:0] w_lfsr_adv;
    logic [33:0] w_enc_cur;
    logic [33:0] w_enc_adv;
    logic [15:0] w_cnt_inc;

    assign w_xfer     = r_valid && instr_ready;
    // A new word may enter when the slot is empty or being drained this cycle
    assign w_load     = en && (!r_valid || instr_ready);
    assign w_lfsr_adv = lfsr_next(r_lfsr);
    assign w_enc_cur  = encode(r_lfsr);
    assign w_enc_adv  = encode(w_lfsr_adv);
    assign w_cnt_inc  = (r_count == 16'hFFFF) ? r_count : (r_count + 16'd1);

    // Next-state, next-word and bookkeeping logic for the generator FSM
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_wcnt_nxt  = r_wcnt;
        w_count_nxt = r_count;
        w_done_nxt  = r_done;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_class_nxt = r_class;

        if (w_load) begin
            w_valid_nxt = 1'b1;
        end else if (w_xfer) begin
            w_valid_nxt = 1'b0;
        end else begin
            w_valid_nxt = r_valid;
        end

        case (r_state)
            ST_WARMUP: begin
                if (w_xfer) begin
                    w_wcnt_nxt = r_wcnt + 32'd1;
                end else begin
                    w_wcnt_nxt = r_wcnt;
                end
                // Once enough NOPs have gone out, the first random word is
                // the current LFSR state, not its successor
                if (w_wcnt_nxt >= WARMUP_NOPS) begin
                    w_state_nxt = ST_RUN;
                    if (w_load) begin
                        {w_class_nxt, w_instr_nxt} = w_enc_cur;
                    end else begin
                        w_instr_nxt = r_instr;
                    end
                end else if (w_load) begin
                    w_instr_nxt = NOP;
                    w_class_nxt = 2'd0;
                end else begin
                    w_instr_nxt = r_instr;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    w_count_nxt = w_cnt_inc;
                    w_lfsr_nxt  = w_lfsr_adv;
                    if ((NUM_INSTR != 32'd0) && ({16'd0, w_cnt_inc} == NUM_INSTR)) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        if (w_load) begin
                            w_instr_nxt = NOP;
                            w_class_nxt = 2'd0;
                        end else begin
                            w_instr_nxt = r_instr;
                        end
                    end else if (w_load) begin
                        {w_class_nxt, w_instr_nxt} = w_enc_adv;
                    end else begin
                        w_instr_nxt = r_instr;
                    end
                end else if (w_load) begin
                    // Refilling an empty slot re-presents the pending word
                    {w_class_nxt, w_instr_nxt} = w_enc_cur;
                end else begin
                    w_instr_nxt = r_instr;
                end
            end
            ST_DONE: begin
                if (w_load) begin
                    w_instr_nxt = NOP;
                    w_class_nxt = 2'd0;
                end else begin
                    w_instr_nxt = r_instr;
                end
            end
            default: begin
                w_state_nxt = ST_WARMUP;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_WARMUP;
            r_lfsr  <= SEED_EFF;
            r_wcnt  <= 32'd0;
            r_count <= 16'd0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_class <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_class <= w_class_nxt;
        end
    end

    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_class = r_class;
    assign instr_count = r_count;
    assign done        = r_done;

endmodule

// File: tb/tb_rv32_instr_stim_gen.sv
// -----------------------------------------------------------------------------
// Testbench for rv32_instr_stim_gen. Three instances with different parameter
// sets share clk/reset_n. Expected words come from a reference model that
// computes the k-th transferred word directly from the stream rules.
// -----------------------------------------------------------------------------
module tb_rv32_instr_stim_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [31:0] A_SEED = 32'h00000017;
    localparam int          A_NUM  = 100;
    localparam int          A_WARM = 2;
    localparam logic [3:0]  A_CM   = 4'b0011;
    localparam logic [2:0]  A_LM   = 3'b100;

    localparam logic [31:0] B_SEED = 32'h00000001;
    localparam int          B_NUM  = 5;
    localparam int          B_WARM = 2;
    localparam logic [3:0]  B_CM   = 4'b1111;
    localparam logic [2:0]  B_LM   = 3'b111;

    localparam logic [31:0] C_SEED = 32'h00000000;
    localparam int          C_NUM  = 0;
    localparam int          C_WARM = 2;
    localparam logic [3:0]  C_CM   = 4'b0010;
    localparam logic [2:0]  C_LM   = 3'b100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic en_a = 1'b1, rdy_a = 1'b1, val_a, done_a;
    logic [31:0] ins_a;
    logic [1:0]  cls_a;
    logic [15:0] cnt_a;
    logic en_b = 1'b1, rdy_b = 1'b1, val_b, done_b;
    logic [31:0] ins_b;
    logic [1:0]  cls_b;
    logic [15:0] cnt_b;
    logic en_c = 1'b1, rdy_c = 1'b1, val_c, done_c;
    logic [31:0] ins_c;
    logic [1:0]  cls_c;
    logic [15:0] cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32_instr_stim_gen #(.SEED(A_SEED), .NUM_INSTR(A_NUM), .WARMUP_NOPS(A_WARM),
                          .CLASS_MASK(A_CM), .LOAD_F3_MASK(A_LM)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .instr_ready(rdy_a),
        .instr_valid(val_a), .instr(ins_a), .instr_class(cls_a),
        .instr_count(cnt_a), .done(done_a));

    rv32_instr_stim_gen #(.SEED(B_SEED), .NUM_INSTR(B_NUM), .WARMUP_NOPS(B_WARM),
                          .CLASS_MASK(B_CM), .LOAD_F3_MASK(B_LM)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .instr_ready(rdy_b),
        .instr_valid(val_b), .instr(ins_b), .instr_class(cls_b),
        .instr_count(cnt_b), .done(done_b));

    rv32_instr_stim_gen #(.SEED(C_SEED), .NUM_INSTR(C_NUM), .WARMUP_NOPS(C_WARM),
                          .CLASS_MASK(C_CM), .LOAD_F3_MASK(C_LM)) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en_c), .instr_ready(rdy_c),
        .instr_valid(val_c), .instr(ins_c), .instr_class(cls_c),
        .instr_count(cnt_c), .done(done_c));

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_step(input logic [31:0] r);
        if (r[0]) return (r >> 1) ^ 32'h80200003;
        return r >> 1;
    endfunction

    function automatic logic [33:0] m_encode(input logic [31:0] r, input logic [3:0] cmask,
                                             input logic [2:0] lmask);
        logic [31:0] rd, rs1, rs2, f3, imm, f, f7, w;
        int sel, cls;
        rd  = (r >> 2)  & 32'd31;
        rs1 = (r >> 7)  & 32'd31;
        rs2 = (r >> 12) & 32'd31;
        f3  = (r >> 17) & 32'd7;
        imm = r >> 20;
        sel = int'(r & 32'd3);
        cls = -1;
        for (int s = 0; s < 4; s++)
            if (cls < 0 && cmask[(sel + s) % 4]) cls = (sel + s) % 4;
        if (cls < 0) return {2'd0, NOP};
        case (cls)
            0: begin
                if (f3 == 32'd5) imm = imm & 32'h41F;
                else if (f3 == 32'd1) imm = imm & 32'h1F;
                w = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            1: begin
                f = f3 & {29'd0, lmask};
                if (f == 32'd3 || f == 32'd6 || f == 32'd7) f = 32'd2;
                w = (imm << 20) | (rs1 << 15) | (f << 12) | (rd << 7) | 32'h03;
            end
            2: begin
                f = f3 & 32'd3;
                if (f == 32'd3) f = 32'd2;
                w = ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f << 12)
                    | ((imm & 32'd31) << 7) | 32'h23;
            end
            default: begin
                f7 = ((f3 == 32'd0 || f3 == 32'd5) && r[20]) ? 32'h20 : 32'h0;
                w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            end
        endcase
        return {2'(cls), w};
    endfunction

    // k-th transferred word of the stream: NOP warm-up, NUM random words, NOPs
    function automatic logic [33:0] m_word(input int k, input logic [31:0] seed,
                                           input logic [3:0] cmask, input logic [2:0] lmask,
                                           input int num, input int warm);
        logic [31:0] r;
        int j;
        j = k - warm;
        if (k < warm || (num != 0 && j >= num)) return {2'd0, NOP};
        r = (seed == 32'd0) ? 32'd1 : seed;
        repeat (j) r = m_step(r);
        return m_encode(r, cmask, lmask);
    endfunction

    function automatic logic [15:0] m_count(input int k, input int warm, input int num);
        int j;
        j = k - warm;
        if (j < 0) j = 0;
        if (num != 0 && j > num) j = num;
        if (j > 65535) j = 65535;
        return 16'(j);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        en_a = 1'b1; rdy_a = 1'b1; en_b = 1'b1; rdy_b = 1'b1; en_c = 1'b1; rdy_c = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        en_a = 1'b1; rdy_a = 1'b1; en_b = 1'b1; rdy_b = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", val_a); end
        n_tests++; if (ins_a !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h expected %h", ins_a, NOP); end
        n_tests++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", cnt_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done_a); end
        n_tests++; if (cls_b !== 2'd0 || val_b !== 1'b0) begin n_fail++; $display("FAIL rst_b: got cls %0d valid %b expected 0 0", cls_b, val_b); end
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++; if (val_a !== 1'b1 || ins_a !== NOP || cls_a !== 2'd0) begin
            n_fail++; $display("FAIL rst_first_word: got valid %b instr %h cls %0d expected 1 %h 0", val_a, ins_a, cls_a, NOP);
        end
        n_tests++; if (cnt_a !== 16'd0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_first_count: got %0d/%b expected 0/0", cnt_a, done_a);
        end
    endtask

    task automatic test_warmup_encode();
        logic [31:0] exp_w [4];
        logic [1:0]  exp_c [4];
        exp_w[0] = NOP; exp_w[1] = NOP; exp_w[2] = 32'h00000003; exp_w[3] = 32'h00000033;
        exp_c[0] = 2'd0; exp_c[1] = 2'd0; exp_c[2] = 2'd1; exp_c[3] = 2'd3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (val_b !== 1'b1 || ins_b !== exp_w[i] || cls_b !== exp_c[i]) begin
                n_fail++; $display("FAIL warmup_word%0d: got valid %b %h cls %0d expected 1 %h cls %0d",
                                   i, val_b, ins_b, cls_b, exp_w[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_warmup_en_drop();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        en_b = 1'b0;
        @(negedge clk);
        n_tests++; if (val_b !== 1'b0 || cnt_b !== 16'd0) begin
            n_fail++; $display("FAIL endrop_gap: got valid %b count %0d expected 0 0", val_b, cnt_b);
        end
        en_b = 1'b1; rdy_b = 1'b0;
        @(negedge clk);
        n_tests++; if (val_b !== 1'b1 || ins_b !== 32'h00000003 || cls_b !== 2'd1) begin
            n_fail++; $display("FAIL endrop_first: got valid %b %h cls %0d expected 1 00000003 cls 1", val_b, ins_b, cls_b);
        end
        rdy_b = 1'b1;
        @(negedge clk);
        n_tests++; if (ins_b !== 32'h00000033 || cnt_b !== 16'd1) begin
            n_fail++; $display("FAIL endrop_second: got %h count %0d expected 00000033 count 1", ins_b, cnt_b);
        end
    endtask

    task automatic test_budget();
        int k;
        logic [33:0] e;
        do_reset();
        k = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            e = m_word(k, B_SEED, B_CM, B_LM, B_NUM, B_WARM);
            n_tests++; if (ins_b !== e[31:0] || cls_b !== e[33:32]) begin
                n_fail++; $display("FAIL budget_word k=%0d: got %h/%0d expected %h/%0d", k, ins_b, cls_b, e[31:0], e[33:32]);
            end
            n_tests++; if (cnt_b !== m_count(k, B_WARM, B_NUM)) begin
                n_fail++; $display("FAIL budget_count k=%0d: got %0d expected %0d", k, cnt_b, m_count(k, B_WARM, B_NUM));
            end
            n_tests++; if (done_b !== (k >= B_WARM + B_NUM)) begin
                n_fail++; $display("FAIL budget_done k=%0d: got %b expected %b", k, done_b, (k >= B_WARM + B_NUM));
            end
            if (val_b && rdy_b) k++;
        end
    endtask

    task automatic test_backpressure();
        int k, cyc, stall;
        logic [33:0] e;
        do_reset();
        k = 0; cyc = 0; stall = 0;
        while (k < 110 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            e = m_word(k, A_SEED, A_CM, A_LM, A_NUM, A_WARM);
            if (val_a) begin
                n_tests++; if (ins_a !== e[31:0] || cls_a !== e[33:32]) begin
                    n_fail++; $display("FAIL bp_word k=%0d: got %h/%0d expected %h/%0d", k, ins_a, cls_a, e[31:0], e[33:32]);
                end
            end
            n_tests++; if (cnt_a !== m_count(k, A_WARM, A_NUM)) begin
                n_fail++; $display("FAIL bp_count k=%0d: got %0d expected %0d", k, cnt_a, m_count(k, A_WARM, A_NUM));
            end
            n_tests++; if (done_a !== (k >= A_WARM + A_NUM)) begin
                n_fail++; $display("FAIL bp_done k=%0d: got %b expected %b", k, done_a, (k >= A_WARM + A_NUM));
            end
            if (k >= 20 && stall < 5) begin
                rdy_a = 1'b0; en_a = 1'b1; stall++;
            end else if (k < 40) begin
                rdy_a = 1'b1; en_a = 1'b1;
            end else begin
                rdy_a = ($urandom_range(3) != 0);
                en_a  = ($urandom_range(3) != 0);
            end
            if (val_a && rdy_a) k++;
        end
        n_tests++; if (k < 110) begin n_fail++; $display("FAIL bp_timeout: got %0d words expected 110", k); end
    endtask

    task automatic test_reset_midrun();
        int k;
        logic [33:0] e;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            k = 0;
            for (int cyc = 0; cyc < 200 && k < 37; cyc++) begin
                @(negedge clk);
                e = m_word(k, A_SEED, A_CM, A_LM, A_NUM, A_WARM);
                n_tests++; if (val_a !== 1'b1 || ins_a !== e[31:0]) begin
                    n_fail++; $display("FAIL midrun_word pass=%0d k=%0d: got %b %h expected 1 %h", pass, k, val_a, ins_a, e[31:0]);
                end
                if (val_a && rdy_a) k++;
            end
            n_tests++; if (k != 37) begin n_fail++; $display("FAIL midrun_timeout: got %0d words expected 37", k); end
            if (pass == 0) begin
                @(posedge clk);
                #2;
                reset_n = 1'b0;
                #1;
                n_tests++; if (val_a !== 1'b0 || ins_a !== NOP || cnt_a !== 16'd0 || done_a !== 1'b0) begin
                    n_fail++; $display("FAIL midrun_async: got valid %b %h count %0d done %b expected 0 %h 0 0", val_a, ins_a, cnt_a, done_a, NOP);
                end
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
    endtask

    task automatic test_class_mask();
        int k, cyc;
        logic [33:0] e;
        do_reset();
        k = 0; cyc = 0;
        while (k < C_WARM + 1000 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (val_c) begin
                e = m_word(k, C_SEED, C_CM, C_LM, C_NUM, C_WARM);
                n_tests++; if (ins_c !== e[31:0] || cls_c !== e[33:32]) begin
                    n_fail++; $display("FAIL cm_word k=%0d: got %h/%0d expected %h/%0d", k, ins_c, cls_c, e[31:0], e[33:32]);
                end
                if (k >= C_WARM) begin
                    n_tests++; if (ins_c[6:0] !== 7'b0000011 || (ins_c[14:12] !== 3'd0 && ins_c[14:12] !== 3'd4)) begin
                        n_fail++; $display("FAIL cm_opcode k=%0d: got op %b f3 %0d expected 0000011 f3 0/4", k, ins_c[6:0], ins_c[14:12]);
                    end
                end
            end
            rdy_c = ($urandom_range(4) != 0);
            en_c  = ($urandom_range(4) != 0);
            if (val_c && rdy_c) k++;
        end
        n_tests++; if (k < C_WARM + 1000) begin n_fail++; $display("FAIL cm_timeout: got %0d words expected %0d", k, C_WARM + 1000); end
    endtask

    initial begin
        test_reset();
        test_warmup_encode();
        test_warmup_en_drop();
        test_budget();
        test_backpressure();
        test_reset_midrun();
        test_class_mask();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
